// File: rtl/rtm_wr_arb_pkg.sv
// Shared constants for the RTM write-port arbiter: geometry defaults, requester ids, FSM states.
// Geometry comes from `S, `R and `RTM_DEPTH. Defaults below apply when the build does not define them.
`ifndef S
`define S 2
`endif
`ifndef R
`define R 2
`endif
`ifndef RTM_DEPTH
`define RTM_DEPTH 64
`endif

package rtm_wr_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int S_DEF      = `S;
  localparam int R_DEF      = `R;
  localparam int ADDR_W_DEF = $clog2(`RTM_DEPTH);

  localparam int REQ_CONV  = 0;
  localparam int REQ_POOL  = 1;
  localparam int REQ_ADD   = 2;
  localparam int REQ_REMAP = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtm_wr_arb_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rtm_wr_arb_rr
  import rtm_wr_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          found
);

  // Scanning from the farthest offset down lets the nearest hit win without a break.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt   = IW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtm_wr_arb.sv
// RTM write-port arbiter: round-robin with burst locking and a one-deep output register.
// Optional per-requester wait counters are enabled with RTM_WR_ARB_STATS_EN.
module rtm_wr_arb
  import rtm_wr_arb_pkg::*;
#(
  parameter  int N_REQ  = N_REQ_DEF,
  parameter  int S      = S_DEF,
  parameter  int R      = R_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int IW     = idx_w(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_vld,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*S-1:0]          req_en,
  input  logic [N_REQ*S*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*S*R*8-1:0]      req_din,
  output logic [N_REQ-1:0]            req_rdy,
  output logic                        rtm_wr_vld,
  output logic [S-1:0]                rtm_wr_en,
  output logic [S*ADDR_W-1:0]         rtm_wr_addr,
  output logic [S*R*8-1:0]            rtm_din,
  output logic [IW-1:0]               owner,
`ifdef RTM_WR_ARB_STATS_EN
  input  logic                        stat_clr,
  output logic [N_REQ*32-1:0]         stat_wait,
`endif
  output logic                        busy
);

  localparam int DW = S * R * 8;
  localparam int AW = S * ADDR_W;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] rr_gnt;
  logic          rr_found;
  logic          accept;

  logic          vld_q, vld_d;
  logic [S-1:0]  en_q, en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    return (int'(x) == N_REQ - 1) ? '0 : IW'(int'(x) + 1);
  endfunction

  rtm_wr_arb_rr #(.N(N_REQ)) u_rr (
    .req   (req_vld),
    .ptr   (ptr_q),
    .gnt   (rr_gnt),
    .found (rr_found)
  );

  // busy covers the opening beat of a multi-beat burst as well as the locked beats.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sel_idx = owner_q;
    req_rdy = '0;
    busy    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          sel_idx         = rr_gnt;
          owner_d         = rr_gnt;
          req_rdy[rr_gnt] = 1'b1;
          if (req_last[rr_gnt]) begin
            ptr_d = next_idx(rr_gnt);
          end else begin
            state_d = ST_LOCK;
            busy    = 1'b1;
          end
        end
      end
      ST_LOCK: begin
        busy             = 1'b1;
        req_rdy[owner_q] = req_vld[owner_q];
        if (req_vld[owner_q] && req_last[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(owner_q);
        end
      end
    endcase
    if (rst) begin
      req_rdy = '0;
      busy    = 1'b0;
    end
  end

  assign accept = |req_rdy;

  always_comb begin
    vld_d  = accept;
    en_d   = en_q;
    addr_d = addr_q;
    din_d  = din_q;
    if (accept) begin
      en_d   = req_en[sel_idx*S +: S];
      addr_d = req_addr[sel_idx*AW +: AW];
      din_d  = req_din[sel_idx*DW +: DW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= IW'(REQ_CONV);
      vld_q   <= 1'b0;
      // NOTE: the datapath register is reset too, so the RTM ports read zero right after reset.
      en_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      vld_q   <= vld_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign rtm_wr_vld  = vld_q;
  assign rtm_wr_en   = en_q;
  assign rtm_wr_addr = addr_q;
  assign rtm_din     = din_q;
  assign owner       = owner_q;

`ifdef RTM_WR_ARB_STATS_EN
  logic [31:0] wait_q [N_REQ];
  logic [31:0] wait_d [N_REQ];

  // Clear wins over increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (stat_clr) begin
        wait_d[i] = '0;
      end else if (req_vld[i] && !req_rdy[i] && (wait_q[i] != '1)) begin
        wait_d[i] = wait_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) wait_q[i] <= '0;
      else     wait_q[i] <= wait_d[i];
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
    assign stat_wait[gi*32 +: 32] = wait_q[gi];
  end
`endif

endmodule

// File: tb/tb_rtm_wr_arb.sv
// Self-checking bench for rtm_wr_arb: per-cycle vector table plus a scoreboard for the RTM port.
// Stats checks run when RTM_WR_ARB_STATS_EN is defined.
module tb_rtm_wr_arb;
  import rtm_wr_arb_pkg::*;

  localparam int NR = N_REQ_DEF;
  localparam int NS = S_DEF;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = S_DEF * R_DEF * 8;
  localparam int BW = NS * AW;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR-1:0]       req_vld, req_last, req_rdy;
  logic [NR*NS-1:0]    req_en;
  logic [NR*BW-1:0]    req_addr;
  logic [NR*DW-1:0]    req_din;
  logic                rtm_wr_vld;
  logic [NS-1:0]       rtm_wr_en;
  logic [BW-1:0]       rtm_wr_addr;
  logic [DW-1:0]       rtm_din;
  logic [1:0]          owner;
  logic                busy;
  logic                stat_clr;
  logic [NR*32-1:0]    stat_wait;

  always #5 clk = ~clk;

  rtm_wr_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_last    (req_last),
    .req_en      (req_en),
    .req_addr    (req_addr),
    .req_din     (req_din),
    .req_rdy     (req_rdy),
    .rtm_wr_vld  (rtm_wr_vld),
    .rtm_wr_en   (rtm_wr_en),
    .rtm_wr_addr (rtm_wr_addr),
    .rtm_din     (rtm_din),
    .owner       (owner),
`ifdef RTM_WR_ARB_STATS_EN
    .stat_clr    (stat_clr),
    .stat_wait   (stat_wait),
`endif
    .busy        (busy)
  );

`ifndef RTM_WR_ARB_STATS_EN
  assign stat_wait = '0;
`endif

  typedef struct {
    logic [NR-1:0] vld;
    logic [NR-1:0] last;
    logic [NR-1:0] en_zero;
    logic [NR-1:0] exp_rdy;
    logic          exp_busy;
  } vec_t;

  typedef struct {
    logic          vld;
    logic [NS-1:0] en;
    logic [BW-1:0] addr;
    logic [DW-1:0] din;
  } beat_t;

  vec_t  tbl[$];
  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    beat_cnt[NR];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [NR-1:0] vld, last, en_zero, exp_rdy, input logic exp_busy);
    vec_t v;
    v.vld = vld; v.last = last; v.en_zero = en_zero; v.exp_rdy = exp_rdy; v.exp_busy = exp_busy;
    return v;
  endfunction

  // One cycle: score the beat registered at the last edge, drive new inputs, check rdy/busy,
  // and queue the beat the bench expects the DUT to register at the coming edge.
  task automatic step(input string tag, input logic r, input vec_t v);
    beat_t e;
    int    g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " wr_vld"}, 256'(rtm_wr_vld), 256'(e.vld));
      if (e.vld) begin
        check({tag, " wr_en"},   256'(rtm_wr_en),   256'(e.en));
        check({tag, " wr_addr"}, 256'(rtm_wr_addr), 256'(e.addr));
        check({tag, " din"},     256'(rtm_din),     256'(e.din));
      end
    end
    rst      = r;
    req_vld  = v.vld;
    req_last = v.last;
    for (int i = 0; i < NR; i++) begin
      req_en[i*NS +: NS] = v.en_zero[i] ? '0 : '1;
      for (int b = 0; b < NS; b++)
        req_addr[(i*NS+b)*AW +: AW] = AW'(i*8 + beat_cnt[i] + b*32);
      req_din[i*DW +: DW] = DW'({$urandom, $urandom});
    end
    #1;
    check({tag, " req_rdy"}, 256'(req_rdy), 256'(v.exp_rdy));
    check({tag, " busy"},    256'(busy),    256'(v.exp_busy));
    e.vld = |v.exp_rdy;
    e.en = '0; e.addr = '0; e.din = '0;
    g = 0;
    for (int i = 0; i < NR; i++) if (v.exp_rdy[i]) g = i;
    if (e.vld) begin
      e.en   = req_en[g*NS +: NS];
      e.addr = req_addr[g*BW +: BW];
      e.din  = req_din[g*DW +: DW];
      beat_cnt[g]++;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_last = '0; req_en = '0; req_addr = '0; req_din = '0;
    stat_clr = 1'b0;
    for (int i = 0; i < NR; i++) beat_cnt[i] = 0;

    // Requester 2, 4-beat burst, then single beats from 0/1/3 to expose the pointer at 3.
    tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1));
    tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1));
    tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1));
    tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b1011, 4'b1111, 4'b0000, 4'b1000, 1'b0));
    tbl.push_back(mk(4'b1011, 4'b1111, 4'b0000, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b1011, 4'b1111, 4'b0000, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b1011, 4'b1111, 4'b0000, 4'b1000, 1'b0));
    // All four with 2-beat bursts from pointer 0: order 0,1,2,3, no interleave.
    tbl.push_back(mk(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b1111, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b1110, 4'b0000, 4'b0000, 4'b0010, 1'b1));
    tbl.push_back(mk(4'b1110, 4'b0010, 4'b0000, 4'b0010, 1'b1));
    tbl.push_back(mk(4'b1100, 4'b0000, 4'b0000, 4'b0100, 1'b1));
    tbl.push_back(mk(4'b1100, 4'b0100, 4'b0000, 4'b0100, 1'b1));
    tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1));
    tbl.push_back(mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    // Owner 0 stalls 3 cycles mid-burst; requester 1 must wait for 0's last.
    tbl.push_back(mk(4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0011, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    // Single-beat bursts from 1 and 3 alternate (pointer starts at 2).
    tbl.push_back(mk(4'b1010, 4'b1010, 4'b0000, 4'b1000, 1'b0));
    tbl.push_back(mk(4'b1010, 4'b1010, 4'b0000, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b1010, 4'b1010, 4'b0000, 4'b1000, 1'b0));
    tbl.push_back(mk(4'b1010, 4'b1010, 4'b0000, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    // Beat with all bank enables low still passes through and takes a slot.
    tbl.push_back(mk(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));

    step("reset0", 1'b1, mk('0, '0, '0, '0, 1'b0));
    step("reset1", 1'b1, mk('0, '0, '0, '0, 1'b0));
    check("rst wr_vld", 256'(rtm_wr_vld), 256'(0));
    check("rst owner",  256'(owner),      256'(0));

    for (int n = 0; n < tbl.size(); n++)
      step($sformatf("vec%0d", n), 1'b0, tbl[n]);

    // Reset mid-burst: pointer left at 3 beforehand so a kept pointer would pick 3 instead of 2.
    step("mr_single", 1'b0, mk(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0));
    step("mr_beat1",  1'b0, mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1));
    step("mr_rst",    1'b1, mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    check("mr wr_vld",  256'(rtm_wr_vld),  256'(0));
    check("mr wr_en",   256'(rtm_wr_en),   256'(0));
    check("mr wr_addr", 256'(rtm_wr_addr), 256'(0));
    check("mr din",     256'(rtm_din),     256'(0));
    check("mr owner",   256'(owner),       256'(0));
    step("mr_idle",  1'b0, mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    step("mr_grant", 1'b0, mk(4'b1100, 4'b1100, 4'b0000, 4'b0100, 1'b0));
    check("mr owner2", 256'(owner), 256'(2));

`ifdef RTM_WR_ARB_STATS_EN
    // Pointer is 3; requester 0 is picked and locks, requester 3 then waits 7 cycles.
    stat_clr = 1'b1;
    step("st_clr", 1'b0, mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    stat_clr = 1'b0;
    step("st_lock", 1'b0, mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1));
    for (int k = 0; k < 7; k++)
      step($sformatf("st_wait%0d", k), 1'b0, mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    check("stat_wait3", 256'(stat_wait[3*32 +: 32]), 256'(7));
    check("stat_wait1", 256'(stat_wait[1*32 +: 32]), 256'(0));
    stat_clr = 1'b1;
    step("st_last", 1'b0, mk(4'b1001, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    stat_clr = 1'b0;
    check("stat_wait3 clr", 256'(stat_wait[3*32 +: 32]), 256'(0));
    step("st_g3", 1'b0, mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0));
`endif

    step("drain", 1'b0, mk('0, '0, '0, '0, 1'b0));
    step("drain2", 1'b0, mk('0, '0, '0, '0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
